// File: rtl/ifu_pkg.sv
// Shared fetch-buffer types and constants: 4-entry depth, entry layout {addr, data, fault, par}.
// Pure declarations; no latency or flow control of its own.
package ifu_pkg;

  localparam int FB_DEPTH = 4;
  localparam int FB_PTR_W = 2;
  localparam int FB_CNT_W = 3;

  typedef struct packed {
    logic [31:1] addr;
    logic [63:0] data;
    logic        fault;
    logic        par;
  } fb_entry_t;

  localparam int FB_ENTRY_W = $bits(fb_entry_t);

  function automatic logic [FB_PTR_W-1:0] fb_ptr_add(input logic [FB_PTR_W-1:0] ptr,
                                                     input logic [FB_PTR_W-1:0] n);
    return ptr + n;
  endfunction

endpackage

// File: rtl/ifu_fb_par.sv
// 64-bit even-parity generator for the write path and checker for the head entry.
// Purely combinational; no flow control.
module ifu_fb_par (
  input  logic [63:0] i_gen_data,
  output logic        o_gen_par,
  input  logic [63:0] i_chk_data,
  input  logic        i_chk_par,
  input  logic        i_chk_vld,
  output logic        o_perr
);

  logic w_chk_par;

  assign o_gen_par = ^i_gen_data;
  assign w_chk_par = ^i_chk_data;
  assign o_perr    = i_chk_vld & (i_chk_par != w_chk_par);

endmodule

// File: rtl/rvdff.sv
// Flop primitives: rvdff (synchronous active-high reset) and rvdffe (enable-only, never reset).
// One-cycle latency; no flow control.
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= i_din;
    end
  end

  assign o_dout = r_q;

endmodule

module rvdffe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_q <= i_din;
    end
  end

  assign o_dout = r_q;

endmodule

// File: rtl/ifu_fb_ctl.sv
// 4-entry fetch buffer between the I-cache F2 stage and the aligner; writes visible 1 cycle later, full
// buffer drops writes unless a consume frees a slot (sticky overflow). Parity per entry with RV_FB_PARITY_EN.
module ifu_fb_ctl
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ifc_fetch_req_f2,
  input  logic        ic_hit_f2,
  input  logic [31:1] ifc_fetch_addr_f2,
  input  logic [63:0] ic_data_f2,
  input  logic        ic_access_fault_f2,
  input  logic        exu_flush_final,
  input  logic        ali_consume1,
  input  logic        ali_consume2,
  output logic        fb_valid0,
  output logic        fb_valid1,
  output logic [63:0] fb_data0,
  output logic [63:0] fb_data1,
  output logic [31:1] fb_addr0,
  output logic [31:1] fb_addr1,
  output logic        fb_fault0,
  output logic        fb_fault1,
  output logic        ifu_fb_consume1,
  output logic        ifu_fb_consume2,
  output logic [2:0]  fb_count,
  output logic        fb_full,
  output logic        fb_overflow_err,
  output logic        fb_perr0
);

`ifdef RV_FB_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  // Stored layout, LSB first: [par], fault, data, addr.
  localparam int FAULT_B = PAR_W;
  localparam int DATA_L  = PAR_W + 1;
  localparam int ADDR_L  = PAR_W + 65;
  localparam int STORE_W = FB_ENTRY_W - 1 + PAR_W;

  logic [FB_CNT_W-1:0] r_count;
  logic [FB_PTR_W-1:0] r_rd_ptr;
  logic [FB_PTR_W-1:0] r_wr_ptr;
  logic                r_ovf;

  logic                w_wr;
  logic                w_wr_ok;
  logic                w_c1;
  logic                w_c2;
  logic [1:0]          w_consumed;
  logic [FB_CNT_W-1:0] w_count_after;
  logic [FB_CNT_W-1:0] w_count_nx;
  logic [FB_PTR_W-1:0] w_rd_ptr_nx;
  logic [FB_PTR_W-1:0] w_wr_ptr_nx;
  logic                w_ovf_nx;
  logic [FB_PTR_W-1:0] w_rd_ptr1;
  logic [STORE_W-1:0]  w_wr_store;
  logic [STORE_W-1:0]  w_ent_q [FB_DEPTH];
  logic [63:0]         w_head0_dat;
  logic                w_live;

  assign w_live = ~rst;

  assign w_wr = ifc_fetch_req_f2 & ic_hit_f2 & ~exu_flush_final;
  assign w_c2 = ali_consume2 & (r_count >= 3'd2) & ~exu_flush_final;
  assign w_c1 = ali_consume1 & ~ali_consume2 & (r_count >= 3'd1) & ~exu_flush_final;

  // c1 and c2 are mutually exclusive, so {c2,c1} is the consumed count.
  assign w_consumed    = {w_c2, w_c1};
  assign w_count_after = r_count - {1'b0, w_consumed};
  assign w_wr_ok       = w_wr & (w_count_after < 3'(FB_DEPTH));

  always_comb begin
    w_count_nx  = w_count_after + {2'b00, w_wr_ok};
    w_rd_ptr_nx = fb_ptr_add(r_rd_ptr, w_consumed);
    w_wr_ptr_nx = fb_ptr_add(r_wr_ptr, {1'b0, w_wr_ok});
    w_ovf_nx    = r_ovf | (w_wr & ~w_wr_ok);
    if (exu_flush_final) begin
      w_count_nx  = '0;
      w_rd_ptr_nx = '0;
      w_wr_ptr_nx = '0;
    end
  end

  rvdff #(.WIDTH(FB_CNT_W)) u_count_ff (
    .clk    (clk),
    .rst    (rst),
    .i_din  (w_count_nx),
    .o_dout (r_count)
  );

  rvdff #(.WIDTH(FB_PTR_W)) u_rd_ptr_ff (
    .clk    (clk),
    .rst    (rst),
    .i_din  (w_rd_ptr_nx),
    .o_dout (r_rd_ptr)
  );

  rvdff #(.WIDTH(FB_PTR_W)) u_wr_ptr_ff (
    .clk    (clk),
    .rst    (rst),
    .i_din  (w_wr_ptr_nx),
    .o_dout (r_wr_ptr)
  );

  rvdff #(.WIDTH(1)) u_ovf_ff (
    .clk    (clk),
    .rst    (rst),
    .i_din  (w_ovf_nx),
    .o_dout (r_ovf)
  );

`ifdef RV_FB_PARITY_EN
  logic w_gen_par;
  logic w_perr;

  ifu_fb_par u_par (
    .i_gen_data (ic_data_f2),
    .o_gen_par  (w_gen_par),
    .i_chk_data (w_head0_dat),
    .i_chk_par  (w_ent_q[r_rd_ptr][0]),
    .i_chk_vld  (fb_valid0),
    .o_perr     (w_perr)
  );

  assign w_wr_store = {ifc_fetch_addr_f2, ic_data_f2, ic_access_fault_f2, w_gen_par};
  assign fb_perr0   = w_perr;
`else
  assign w_wr_store = {ifc_fetch_addr_f2, ic_data_f2, ic_access_fault_f2};
  assign fb_perr0   = 1'b0;
`endif

  for (genvar gi = 0; gi < FB_DEPTH; gi++) begin : g_ent
    rvdffe #(.WIDTH(STORE_W)) u_ent_ff (
      .clk    (clk),
      .i_en   (w_wr_ok & (r_wr_ptr == FB_PTR_W'(gi))),
      .i_din  (w_wr_store),
      .o_dout (w_ent_q[gi])
    );
  end

  assign w_rd_ptr1   = fb_ptr_add(r_rd_ptr, 2'd1);
  assign w_head0_dat = w_ent_q[r_rd_ptr][DATA_L +: 64];

  // Reset gating keeps outputs quiet before the first reset edge has landed.
  assign fb_count        = w_live ? r_count : 3'd0;
  assign fb_valid0       = (fb_count >= 3'd1);
  assign fb_valid1       = (fb_count >= 3'd2);
  assign fb_full         = (fb_count == 3'(FB_DEPTH));
  assign fb_overflow_err = r_ovf & w_live;
  assign ifu_fb_consume1 = w_c1 & w_live;
  assign ifu_fb_consume2 = w_c2 & w_live;

  assign fb_data0  = w_head0_dat;
  assign fb_addr0  = w_ent_q[r_rd_ptr][ADDR_L +: 31];
  assign fb_fault0 = w_ent_q[r_rd_ptr][FAULT_B];
  assign fb_data1  = w_ent_q[w_rd_ptr1][DATA_L +: 64];
  assign fb_addr1  = w_ent_q[w_rd_ptr1][ADDR_L +: 31];
  assign fb_fault1 = w_ent_q[w_rd_ptr1][FAULT_B];

endmodule

// File: doc/ifu_fb_ctl.md
IFU_FB_CTL -- requirements
Module: ifu_fb_ctl

Interface
REQ-001 SHALL have port clk, input, 1, the single core clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have inputs: ifc_fetch_req_f2 (1, F2 fetch valid), ic_hit_f2 (1, F2 data good), ifc_fetch_addr_f2 (31, [31:1] bundle address), ic_data_f2 (64, fetched bundle), ic_access_fault_f2 (1), exu_flush_final (1, flush).
REQ-004 SHALL have inputs ali_consume1, ali_consume2 (1 each, aligner consumes 1 or 2 head entries).
REQ-005 SHALL have outputs fb_valid0/fb_valid1 (1), fb_data0/fb_data1 (64), fb_addr0/fb_addr1 (31), fb_fault0/fb_fault1 (1): the head and next-to-head entries.
REQ-006 SHALL have outputs ifu_fb_consume1, ifu_fb_consume2 (1 each, qualified consumes returned to fetch control), fb_count (3, occupancy 0..4), fb_full (1), fb_overflow_err (1, sticky), fb_perr0 (1).

Function
REQ-007 SHALL be a 4-entry FIFO with 2-bit rd_ptr/wr_ptr that wrap 3->0 and a 3-bit count.
REQ-008 SHALL write when wr = ifc_fetch_req_f2 & ic_hit_f2 & ~exu_flush_final; entry stores {addr, data, fault}.
REQ-009 Written entry SHALL be visible on the head outputs the cycle after the write (one-cycle latency); no same-cycle bypass.
REQ-010 ifu_fb_consume2 SHALL = ali_consume2 & count>=2 & ~exu_flush_final.
REQ-011 ifu_fb_consume1 SHALL = ali_consume1 & ~ali_consume2 & count>=1 & ~exu_flush_final.
REQ-012 Unqualified consumes (insufficient entries) SHALL be ignored; pointers and count unchanged by them.
REQ-013 count_next SHALL = count + wr_ok - consumed, where consumed is 0, 1 or 2 and wr_ok = wr & (count - consumed < 4).
REQ-014 Write and consume in the same cycle SHALL both take effect; when full, a write with a qualified consume SHALL be accepted.
REQ-015 A write when full with no qualified consume SHALL be dropped and SHALL set fb_overflow_err, which stays set until rst.
REQ-016 exu_flush_final SHALL clear count, rd_ptr and wr_ptr to 0 the next cycle, suppressing any same-cycle write and consume; data storage need not clear.
REQ-017 fb_valid0 SHALL = count>=1; fb_valid1 SHALL = count>=2; data/addr/fault outputs are don't-care when the corresponding valid is 0.
REQ-018 fb_full SHALL = (count==4).
REQ-019 Writes with ic_hit_f2=0 (miss) SHALL not change state.

Reset
REQ-020 While rst=1, the block SHALL drive count=0, pointers=0, fb_valid0/1=0, fb_full=0, fb_overflow_err=0, fb_perr0=0, ifu_fb_consume1/2=0.
REQ-021 rst asserted mid-operation SHALL discard all entries at the next edge, with priority over flush, write and consume.
REQ-022 Data, addr and fault storage SHALL not be reset; those registers are enable-only flops.

Configuration
REQ-023 With macro RV_FB_PARITY_EN defined, each entry SHALL store one even-parity bit over data[63:0], computed at write.
REQ-024 With RV_FB_PARITY_EN defined, fb_perr0 SHALL = fb_valid0 & (stored parity != recomputed parity of fb_data0).
REQ-025 Without RV_FB_PARITY_EN, parity storage SHALL be absent and fb_perr0 SHALL be tied 0.

Structure
REQ-026 Shared package ifu_pkg SHALL hold constant FB_DEPTH=4 and typedef fb_entry_t {addr[31:1], data[63:0], fault, par}.
REQ-027 SHALL contain one sub-module ifu_fb_par (64-bit parity generate/check), instantiated only under RV_FB_PARITY_EN.
REQ-028 State flops SHALL use the codebase's rvdff/rvdffe primitives.

Verification
REQ-029 rst, then 4 hit writes at addrs 0x100,0x104,0x108,0x10C (halfword [31:1] values) with no consumes -> fb_count=4, fb_full=1, fb_addr0=0x100, fb_addr1=0x104.
REQ-030 Full, 5th write with no consume -> write dropped, fb_overflow_err=1 and remains 1 until rst; fb_count stays 4.
REQ-031 Full, write 0x110 with ali_consume2=1 -> ifu_fb_consume2=1, fb_count=3, fb_addr0=0x108; after two consume1 cycles, fb_addr0=0x110, verifying pointer wrap.
REQ-032 count=1 with ali_consume2=1 -> ifu_fb_consume2=0, ifu_fb_consume1=0, fb_count=1.
REQ-033 count=3, flush with simultaneous write and consume1 -> next cycle fb_count=0, fb_valid0=0, both consume outputs 0 during the flush cycle.
REQ-034 With RV_FB_PARITY_EN, force a single bit flip in head data storage -> fb_perr0=1; without the macro -> fb_perr0=0.
